// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle register-file + ALU core.
// Each instruction walks FETCH -> DECODE -> EXEC -> WB and then returns to
// FETCH, or parks in HALT. A retire pulse in WB gives an architectural trace.
// Optional feature macro: CPU_MULTICYCLE_SLT_EN (op 6 = signed set-less-than;
// when undefined, op 6 is a NOP).
//
// Fetch handshake: imem_req is high only in FETCH, and imem_addr (= pc) is
// held constant while imem_req is high. A word is accepted on the rising
// edge where imem_req && imem_ack are both high. imem_ack with imem_req low
// is ignored, so there is never an outstanding fetch outside FETCH.
module cpu_multicycle #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            retire,
    output logic [PC_W-1:0] retire_pc,
    output logic            retire_we,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_wdata,
    output logic            halted
);

    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] regs [NREG];

    // Latched instruction fields
    logic [2:0]      ir_op;
    logic [RW-1:0]   ir_rs1;
    logic [RW-1:0]   ir_rs2;
    logic [4:0]      ir_rd;
    logic [8:0]      ir_imm;

    // Operand, result and branch-decision registers
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_q;
    logic            take_q;

    // Combinational helpers
    logic [XLEN-1:0] imm_x;
    logic [PC_W-1:0] imm_pc;
    logic [RW-1:0]   rd_idx;
    logic [XLEN-1:0] alu_res;
    logic            alu_wr;
    logic            exec_we;
    logic [PC_W-1:0] pc_next;

    // Opcode bits 7:3 and register-field bits above the index width are don't-care.
    logic unused_inst;
    assign unused_inst = ^imem_rdata;

    assign imm_x  = XLEN'($signed(ir_imm));
    assign imm_pc = PC_W'($signed(ir_imm));
    assign rd_idx = ir_rd[RW-1:0];

    // Status outputs are forced quiet while reset is held.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = rst ? '0 : pc;
    assign retire    = (state == S_WB) && !rst;
    assign halted    = (state == S_HALT) && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:  if (imem_ack) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = (ir_op == 3'd7) ? S_HALT : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // ALU: result and whether the op writes a register at all
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b0;
        unique case (ir_op)
            3'd0: begin alu_res = opa + opb;   alu_wr = 1'b1; end
            3'd1: begin alu_res = opa - opb;   alu_wr = 1'b1; end
            3'd2: begin alu_res = opa & opb;   alu_wr = 1'b1; end
            3'd3: begin alu_res = opa | opb;   alu_wr = 1'b1; end
            3'd4: begin alu_res = opa + imm_x; alu_wr = 1'b1; end
            3'd6: begin
`ifdef CPU_MULTICYCLE_SLT_EN
                alu_res = ($signed(opa) < $signed(opb)) ? XLEN'(1) : '0;
                alu_wr  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Writes to r0 are dropped and reported as non-writing.
    assign exec_we = alu_wr && (rd_idx != '0);

    // pc update applied in WB
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (ir_op == 3'd5 && take_q) pc_next = pc + imm_pc;
        else if (ir_op == 3'd7)      pc_next = pc;
    end

    // Datapath: fetch latch, operand read, execute, writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            ir_op        <= '0;
            ir_rs1       <= '0;
            ir_rs2       <= '0;
            ir_rd        <= '0;
            ir_imm       <= '0;
            opa          <= '0;
            opb          <= '0;
            alu_q        <= '0;
            take_q       <= 1'b0;
            retire_pc    <= '0;
            retire_we    <= 1'b0;
            retire_rd    <= '0;
            retire_wdata <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_op  <= imem_rdata[2:0];
                        ir_rs1 <= imem_rdata[8 +: RW];
                        ir_rs2 <= imem_rdata[13 +: RW];
                        ir_rd  <= imem_rdata[22:18];
                        ir_imm <= imem_rdata[31:23];
                    end
                end
                S_DECODE: begin
                    opa <= (ir_rs1 == '0) ? '0 : regs[ir_rs1];
                    opb <= (ir_rs2 == '0) ? '0 : regs[ir_rs2];
                end
                S_EXEC: begin
                    alu_q        <= alu_res;
                    take_q       <= (opa == opb);
                    retire_pc    <= pc;
                    retire_we    <= exec_we;
                    retire_rd    <= ir_rd;
                    retire_wdata <= exec_we ? alu_res : '0;
                end
                S_WB: begin
                    if (retire_we) regs[rd_idx] <= alu_q;
                    pc <= pc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: ISA-level reference model checked every cycle,
// plus literal retire traces for each directed program.
module tb_cpu_multicycle;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int PC_W = 8;

`ifdef CPU_MULTICYCLE_SLT_EN
  localparam logic SLT_ON = 1'b1;
`else
  localparam logic SLT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            retire;
  logic [PC_W-1:0] retire_pc;
  logic            retire_we;
  logic [4:0]      retire_rd;
  logic [XLEN-1:0] retire_wdata;
  logic            halted;

  cpu_multicycle #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .retire_pc(retire_pc), .retire_we(retire_we),
    .retire_rd(retire_rd), .retire_wdata(retire_wdata),
    .halted(halted)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {imm[8:0], rd[4:0], rs2[4:0], rs1[4:0], 5'b0, op[2:0]};
  endfunction

  // ---------------- instruction memory driver ----------------
  logic [31:0] mem [256];
  int ack_wait = 0;
  bit stray_en = 1'b0;

  initial begin : imem_driver
    int req_cnt;
    req_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (req_cnt >= ack_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          req_cnt    = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          req_cnt++;
        end
      end else begin
        req_cnt    = 0;
        imem_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = 32'h0000_0007;  // a HALT word: harmful if ever accepted
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] mr [32];
  logic [7:0]  mpc;
  bit          mhalt;
  logic [31:0] exp_q [$];
  int          log_pc [$];
  logic        log_we [$];
  logic [31:0] log_wd [$];
  int          log_cyc [$];
  int          cyc = 0;
  int          ack_cyc = 0;
  bit          prev_rst = 1'b0;
  bit          prev_retire = 1'b0;

  initial begin : compare
    logic [31:0] w, a, b, res, imm;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic        we;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_imem_req", imem_req, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imem_addr", imem_addr, 0);
        if (prev_rst) begin
          chk("rst_retire_pc", retire_pc, 0);
          chk("rst_retire_we", retire_we, 0);
          chk("rst_retire_rd", retire_rd, 0);
          chk("rst_retire_wdata", retire_wdata, 0);
        end
        mpc = '0;
        mhalt = 1'b0;
        for (int i = 0; i < 32; i++) mr[i] = '0;
        exp_q.delete();
      end else begin
        if (prev_rst) chk("first_req", imem_req, 1);
        if (prev_retire && !mhalt) chk("req_after_retire", imem_req, 1);
        chk("halted", halted, mhalt);
        if (mhalt) begin
          chk("halt_req", imem_req, 0);
          chk("halt_retire", retire, 0);
        end
        if (exp_q.size() != 0) chk("req_in_flight", imem_req, 0);
        if (imem_req) chk("imem_addr", imem_addr, mpc);
        if (imem_req && imem_ack) begin
          exp_q.push_back(imem_rdata);
          ack_cyc = cyc;
        end
        if (retire) begin
          if (exp_q.size() == 0) begin
            chk("retire_without_fetch", 1, 0);
          end else begin
            w   = exp_q.pop_front();
            chk("ack_to_retire", cyc - ack_cyc, 3);
            op  = w[2:0];
            a   = mr[w[12:8]];
            b   = mr[w[17:13]];
            rd  = w[22:18];
            imm = {{23{w[31]}}, w[31:23]};
            res = '0;
            we  = 1'b0;
            case (op)
              3'd0: begin res = a + b;   we = 1'b1; end
              3'd1: begin res = a - b;   we = 1'b1; end
              3'd2: begin res = a & b;   we = 1'b1; end
              3'd3: begin res = a | b;   we = 1'b1; end
              3'd4: begin res = a + imm; we = 1'b1; end
              3'd6: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; we = SLT_ON; end
              default: ;
            endcase
            if (rd == 5'd0) we = 1'b0;
            if (!we) res = '0;
            chk("retire_pc", retire_pc, mpc);
            chk("retire_we", retire_we, we);
            chk("retire_rd", retire_rd, rd);
            chk("retire_wdata", retire_wdata, res);
            log_pc.push_back(int'(retire_pc));
            log_we.push_back(retire_we);
            log_wd.push_back(retire_wdata);
            log_cyc.push_back(cyc);
            if (we) mr[rd] = res;
            if (op == 3'd5) mpc = (a == b) ? mpc + imm[7:0] : mpc + 8'd1;
            else if (op == 3'd7) mhalt = 1'b1;
            else mpc = mpc + 8'd1;
          end
        end
      end
      prev_rst    = rst;
      prev_retire = retire && !rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0007;
  endtask

  task automatic clear_log();
    log_pc.delete(); log_we.delete(); log_wd.delete(); log_cyc.delete();
  endtask

  task automatic enter_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int bound);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!halted) chk("halt_timeout", 0, 1);
  endtask

  // ---------------- hand-computed expectations ----------------
  logic [31:0] p1_wd [15] = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFB, 32'hC, 32'hA,
                              32'h8, 32'hE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1,
                              {31'd0, SLT_ON}, {31'd0, SLT_ON}, 32'd0};
  logic        p1_we [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, SLT_ON, 1'b1, 1'b0};
  int          p2_pc [15] = '{0, 6, 7, 8, 2, 3, 4, 2, 3, 4, 2, 5, 255, 0, 1};
  int          acks;

  // ---------------- test sequence ----------------
  initial begin : test
    // Program 1: ALU ops, r0 write, SLT/NOP, zero-wait fetch
    clear_mem();
    mem[0]  = enc(4, 1, 0, 0, 5);
    mem[1]  = enc(4, 2, 0, 0, -3);
    mem[2]  = enc(0, 3, 1, 2, 0);
    mem[3]  = enc(1, 4, 0, 1, 0);
    mem[4]  = enc(4, 1, 0, 0, 12);
    mem[5]  = enc(4, 2, 0, 0, 10);
    mem[6]  = enc(2, 5, 1, 2, 0);
    mem[7]  = enc(3, 10, 1, 2, 0);
    mem[8]  = enc(4, 0, 0, 0, 7);
    mem[9]  = enc(0, 7, 0, 0, 0);
    mem[10] = enc(4, 1, 0, 0, -1);
    mem[11] = enc(4, 2, 0, 0, 1);
    mem[12] = enc(6, 6, 1, 2, 0);
    mem[13] = enc(0, 9, 6, 0, 0);
    mem[14] = enc(7, 0, 0, 0, 0);
    ack_wait = 0;
    stray_en = 1'b0;
    clear_log();
    leave_reset();
    wait_halt(200);
    chk("p1_count", log_pc.size(), 15);
    if (log_pc.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        chk($sformatf("p1_pc%0d", i), log_pc[i], i);
        chk($sformatf("p1_we%0d", i), log_we[i], p1_we[i]);
        chk($sformatf("p1_wd%0d", i), log_wd[i], p1_wd[i]);
      end
      for (int i = 0; i < 14; i++)
        chk($sformatf("p1_gap%0d", i), log_cyc[i+1] - log_cyc[i], 4);
    end
    repeat (8) @(negedge clk);

    // Program 2: branches incl. pc wrap both ways, 3-cycle ack delay, stray acks
    enter_reset();
    clear_mem();
    mem[0]   = enc(5, 0, 4, 0, 6);
    mem[1]   = enc(7, 0, 0, 0, 0);
    mem[2]   = enc(5, 0, 1, 2, 3);
    mem[3]   = enc(4, 1, 1, 0, 1);
    mem[4]   = enc(5, 0, 1, 1, -2);
    mem[5]   = enc(5, 0, 0, 0, -6);
    mem[6]   = enc(4, 4, 0, 0, 1);
    mem[7]   = enc(4, 2, 0, 0, 2);
    mem[8]   = enc(5, 0, 0, 0, -6);
    mem[255] = enc(5, 0, 4, 0, 9);
    ack_wait = 3;
    stray_en = 1'b1;
    clear_log();
    leave_reset();
    wait_halt(600);
    chk("p2_count", log_pc.size(), 15);
    if (log_pc.size() == 15) begin
      for (int i = 0; i < 15; i++) chk($sformatf("p2_pc%0d", i), log_pc[i], p2_pc[i]);
      chk("p2_wd_r1", log_wd[8], 2);
      chk("p2_beq_we", log_we[11], 0);
      for (int i = 0; i < 14; i++)
        chk($sformatf("p2_gap%0d", i), log_cyc[i+1] - log_cyc[i], 7);
    end

    // Program 3: HALT at pc 3, stays halted with stray acks around
    enter_reset();
    clear_mem();
    mem[0] = enc(4, 1, 0, 0, 5);
    mem[1] = enc(4, 2, 0, 0, 6);
    mem[2] = enc(0, 3, 1, 2, 0);
    mem[3] = enc(7, 0, 0, 0, 0);
    ack_wait = 0;
    clear_log();
    leave_reset();
    wait_halt(200);
    chk("p3_count", log_pc.size(), 4);
    if (log_pc.size() == 4) begin
      chk("p3_add", log_wd[2], 11);
      chk("p3_halt_pc", log_pc[3], 3);
      chk("p3_halt_we", log_we[3], 0);
    end
    repeat (10) @(negedge clk);

    // Program 4: reset asserted during EXEC of the third instruction
    enter_reset();
    clear_mem();
    mem[0] = enc(4, 1, 0, 0, 9);
    mem[1] = enc(4, 2, 0, 0, 4);
    mem[2] = enc(0, 3, 1, 2, 0);
    ack_wait = 1;
    clear_log();
    leave_reset();
    acks = 0;
    for (int n = 0; n < 100 && acks < 3; n++) begin
      @(negedge clk);
      if (imem_req && imem_ack) acks++;
    end
    if (acks < 3) chk("p4_ack_timeout", 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("p4_count", log_pc.size(), 2);

    // Program 5: registers cleared by that reset
    clear_mem();
    mem[0] = enc(0, 3, 1, 2, 0);
    mem[1] = enc(4, 4, 2, 0, 0);
    mem[2] = enc(7, 0, 0, 0, 0);
    ack_wait = 0;
    clear_log();
    leave_reset();
    wait_halt(200);
    chk("p5_count", log_pc.size(), 3);
    if (log_pc.size() == 3) begin
      chk("p5_pc0", log_pc[0], 0);
      chk("p5_we0", log_we[0], 1);
      chk("p5_wd0", log_wd[0], 0);
      chk("p5_wd1", log_wd[1], 0);
      chk("p5_halt_pc", log_pc[2], 2);
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle register-file + ALU core, the successor of the single-cycle reg+ALU CPU. It fetches 32-bit instructions from an external instruction memory over a req/ack handshake. Each instruction goes through a fetch/decode/execute/writeback state machine. A per-instruction retire port gives verification an architectural trace. It adds immediates, a conditional branch, a program counter, halt and configurable widths to the existing register/ALU datapath.

## Interface
- XLEN, 32, data/register width (8..64)
- NREG, 32, register count; power of two, 2..32; register index = low $clog2(NREG) bits of each 5-bit field
- PC_W, 8, program counter width, in instruction units
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_ack
- retire  out  1  one-cycle pulse per completed instruction
- retire_pc  out  PC_W  pc of retired instruction
- retire_we  out  1  retired instruction wrote a register
- retire_rd  out  5  destination field of retired instruction
- retire_wdata  out  XLEN  value written (0 when retire_we=0)
- halted  out  1  core stopped

## Operation
- Fields: op=inst[2:0], rs1=inst[12:8], rs2=inst[17:13], rd=inst[22:18], imm=inst[31:23] (9-bit, sign-extended); inst[7:3] ignored.
- op 0 ADD rd=rs1+rs2; 1 SUB rd=rs1-rs2; 2 AND; 3 OR; 4 ADDI rd=rs1+sext(imm); 5 BEQ: if rs1==rs2 then pc=pc+sext(imm) else pc+1, no write; 6 SLT (see Configuration); 7 HALT.
- Arithmetic is modulo 2^XLEN. pc arithmetic is modulo 2^PC_W and wraps from 2^PC_W-1 to 0.
- r0 always reads 0. Writes to r0 are discarded and retire with retire_we=0.
- States: FETCH, DECODE, EXEC, WB, HALT.
  - FETCH: imem_req=1, imem_addr=pc; hold until imem_ack=1, latch imem_rdata, go DECODE.
  - DECODE: read rs1/rs2 into operand registers.
  - EXEC: ALU result and branch decision registered.
  - WB: register write, pc update, retire pulse; go FETCH, or HALT if op=7.
  - HALT: imem_req=0, halted=1; stays until rst.
- Non-BEQ, non-HALT instructions set pc=pc+1 in WB. HALT retires (we=0) and leaves pc unchanged.
- Handshake: imem_addr stable while imem_req=1. imem_ack with imem_req=0 is ignored. No outstanding fetch outside FETCH.

## Timing
- Reset (edge with rst=1): pc=0, all registers 0, state=FETCH. While rst=1: imem_req=0, retire=0, retire_pc=0, retire_we=0, retire_rd=0, retire_wdata=0, halted=0, imem_addr=0.
- First imem_req=1 is the first cycle with rst=0.
- Latency: ack in fetch cycle k, retire pulse in cycle k+3, next imem_req in cycle k+4. Four cycles per instruction with zero-wait ack; add one per wait cycle.
- Retire outputs are valid only while retire=1 and hold their last value otherwise.
- rst mid-operation, in any state including a pending fetch, aborts without retire. Next cycle restarts at pc=0. Register contents are cleared.
- A register written in WB is visible to the next instruction's DECODE (no hazard possible).

## Configuration
- CPU_MULTICYCLE_SLT_EN defined: op 6 is SLT, rd = ($signed(rs1) < $signed(rs2)) ? 1 : 0 at XLEN width.
- Not defined: op 6 is a NOP; it retires with retire_we=0, retire_wdata=0, pc+1.

## Test plan
- Zero-wait ack; ADDI r1,r0,5; ADDI r2,r0,-3 (imm=0x1FD); ADD r3,r1,r2 -> retires at pcs 0,1,2 with wdata 5, 0xFFFFFFFD, 2; retire every 4 cycles.
- r1=5; SUB r4,r0,r1; AND/OR with r1=0xC,r2=0xA -> wdata 0xFFFFFFFB, 0x8, 0xE; ADDI r0,r0,7 -> retire_we=0, later ADD r5,r0,r0 gives 0.
- BEQ r1,r1,imm=-2 at pc=4 -> next imem_addr=2. BEQ r1,r2 unequal at pc=255 (PC_W=8) -> next imem_addr=0.
- imem_ack delayed 3 cycles -> imem_req held, imem_addr constant, no retire until 3 cycles after ack; ack pulsed outside FETCH has no effect.
- HALT at pc=3 -> retire pc=3 we=0, halted=1, imem_req=0 forever. Assert rst in EXEC of a later run -> no retire, next fetch at addr 0, registers read 0.
- r1=-1, r2=1, op 6 rd=r6 -> with CPU_MULTICYCLE_SLT_EN wdata=1, we=1; without it we=0 and r6 stays 0.
